search_array_ctrl: RTL

// Control and result-collection core for an array of NUM_OF_MODULES tap-search engines.

---
 rtl/search_pkg.sv | 31 +++
 rtl/search_result_fifo.sv | 81 ++++++++
 rtl/search_array_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/search_pkg.sv
`default_nettype none
// ============================================================================
// Module   : search_pkg
// Purpose  : Shared types and sizing helpers for the tap-search array
//            controller: FSM state encoding and coefficient/id width helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package search_pkg;

  localparam int BYTE_W = 8;

  // Run/stop controller states, explicitly encoded on two bits.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Coefficient word width: one byte per tap.
  function automatic int coef_w(input int taps);
    return taps * BYTE_W;
  endfunction

  // Engine index width, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/search_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : search_result_fifo
// Purpose  : Synchronous FIFO holding captured {id, coefficient} results.
//            full/empty are registered; a push is refused while full even if
//            a pop happens in the same cycle.
// Ports    : clk, rst_n          clock, async active-low reset
//            push, push_data     write request and entry
//            pop                 read request (ignored while empty)
//            head_data           entry at the head of the queue
//            full, empty         registered status flags
// Revision : 1.0 - initial release
// ============================================================================
module search_result_fifo
  import search_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;

endmodule
`default_nettype wire

// File: rtl/search_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : search_array_ctrl
// Purpose  : Run/stop control and round-robin result collection for an array
//            of tap-search engines; results are queued for a serial link.
// Ports    : clk, rst_n      clock, async active-low reset
//            start_n         raw start/stop button (active low, async)
//            enable_mask     per-engine participation
//            mod_start       run level to each engine
//            mod_found       per-engine result-available flags
//            mod_co_buf      packed per-engine coefficient words
//            mod_res         one-cycle acknowledge to the granted engine
//            out_valid/out_ready/out_id/out_data  result stream (FIFO head)
//            fifo_full       result FIFO full, arbitration stalled
//            found_smth      sticky result flag since last run start
//            found_cnt       saturating result count since last run start
// Revision : 1.0 - initial release
// ============================================================================
module search_array_ctrl
  import search_pkg::*;
#(
  parameter  int NUM_OF_TAPS    = 6,
  parameter  int NUM_OF_MODULES = 20,
  parameter  int FIFO_DEPTH     = 8,
  parameter  int CNT_W          = 16,
  localparam int COEF_W         = coef_w(NUM_OF_TAPS),
  localparam int ID_W           = id_w(NUM_OF_MODULES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_n,
  input  logic [NUM_OF_MODULES-1:0]        enable_mask,
  output logic [NUM_OF_MODULES-1:0]        mod_start,
  input  logic [NUM_OF_MODULES-1:0]        mod_found,
  input  logic [NUM_OF_MODULES*COEF_W-1:0] mod_co_buf,
  output logic [NUM_OF_MODULES-1:0]        mod_res,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ID_W-1:0]                  out_id,
  output logic [COEF_W-1:0]                out_data,
  output logic                             fifo_full,
  output logic                             found_smth,
  output logic [CNT_W-1:0]                 found_cnt
);

  localparam int NM = NUM_OF_MODULES;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [COEF_W-1:0] coef;
  } result_t;

  // ---------------- start button synchroniser and press detect -------------
  logic sync1_q, sync2_q, sync3_q;
  logic press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= start_n;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Falling edge of the synchronised button: a held button is one press.
  assign press = sync3_q & ~sync2_q;

  // ---------------- FSM ------------------------------------------------------
  state_e               state_q, state_d;
  logic [NM-1:0]        mod_start_q, mod_start_d;
  logic                 run_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (press) state_d = ST_RUN;
      ST_RUN:   if (press) state_d = ST_DRAIN;
      ST_DRAIN: if ((mod_found & enable_mask) == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered from the next state so engines start one cycle after press
  // and a cleared enable bit drops the engine on the following cycle.
  always_comb begin
    mod_start_d = (state_d == ST_RUN) ? enable_mask : '0;
    run_clear   = (state_q == ST_IDLE) && press;
  end

  // ---------------- round-robin arbiter --------------------------------------
  logic [NM-1:0]     mod_res_q, mod_res_d;
  logic [NM-1:0]     pending;
  logic [2*NM-1:0]   masked;
  logic [ID_W:0]     hit_idx;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              arb_en;
  logic              fifo_empty;
  result_t           push_entry, head_entry;

  // An engine acknowledged last cycle may still show found; mask it.
  assign pending = mod_found & enable_mask & ~mod_res_q;
  assign arb_en  = (state_q != ST_IDLE) && !fifo_full && (pending != '0);

  // Doubled request vector with bits below rr_ptr cleared: the lowest
  // remaining set bit is the first requester at or after rr_ptr, wrapping.
  always_comb begin
    masked  = {pending, pending} & ({(2*NM){1'b1}} << rr_ptr_q);
    hit_idx = '0;
    for (int i = 2*NM-1; i >= 0; i--) begin
      if (masked[i]) hit_idx = (ID_W+1)'(i);
    end
    if (hit_idx >= (ID_W+1)'(NM)) begin
      grant_id = ID_W'(hit_idx - (ID_W+1)'(NM));
    end else begin
      grant_id = ID_W'(hit_idx);
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    mod_res_d = '0;
    if (arb_en) begin
      rr_ptr_d  = (grant_id == ID_W'(NM-1)) ? '0 : grant_id + 1'b1;
      mod_res_d = NM'(1) << grant_id;
    end
  end

  // ---------------- result counter and sticky flag ---------------------------
  logic [CNT_W-1:0] found_cnt_q, found_cnt_d;
  logic             found_smth_q, found_smth_d;

  always_comb begin
    found_cnt_d  = found_cnt_q;
    found_smth_d = found_smth_q;
    if (run_clear) begin
      found_cnt_d  = '0;
      found_smth_d = 1'b0;
    end else if (arb_en) begin
      found_smth_d = 1'b1;
      if (found_cnt_q != '1) found_cnt_d = found_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_start_q  <= '0;
      mod_res_q    <= '0;
      rr_ptr_q     <= '0;
      found_cnt_q  <= '0;
      found_smth_q <= 1'b0;
    end else begin
      mod_start_q  <= mod_start_d;
      mod_res_q    <= mod_res_d;
      rr_ptr_q     <= rr_ptr_d;
      found_cnt_q  <= found_cnt_d;
      found_smth_q <= found_smth_d;
    end
  end

  // ---------------- result FIFO ----------------------------------------------
  always_comb begin
    push_entry.id   = grant_id;
    push_entry.coef = mod_co_buf[int'(grant_id)*COEF_W +: COEF_W];
  end

  search_result_fifo #(
    .WIDTH (ID_W + COEF_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (arb_en),
    .push_data (push_entry),
    .pop       (out_ready),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign out_id     = head_entry.id;
  assign out_data   = head_entry.coef;
  assign mod_start  = mod_start_q;
  assign mod_res    = mod_res_q;
  assign found_cnt  = found_cnt_q;
  assign found_smth = found_smth_q;

endmodule
`default_nettype wire
